hsv_seq_ctrl: RTL



---
 rtl/hsv_seq_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hsv_seq_ctrl.sv
// RGB-to-HSV pixel sequencer: valid/ready input, one shared 9-bit restoring
// divider reused for the hue fraction and the saturation ratio, backpressured output.
module hsv_seq_ctrl #(
  parameter int unsigned SKIP_ZERO = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] hsv,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PREP, DIV_HUE, DIV_SAT, POST, OUT} state_t;
  typedef enum logic [1:0] {SEL_R, SEL_G, SEL_B} sel_t;

  state_t      state;
  sel_t        sel;
  logic [7:0]  r_q, g_q, b_q;
  logic [7:0]  mx, diff;
  logic        neg;
  logic [8:0]  rem, quo, qh, qs;
  logic [3:0]  cnt;

  sel_t        sel_c;
  logic [7:0]  mx_c, mn_c, in1_c, in2_c, diff_c, num_c;
  logic        neg_c;
  logic [7:0]  den;
  logic        ge;
  logic [8:0]  rem_sub, rem_nxt, q_nxt;
  logic [6:0]  t_c, sat_c;
  logic [8:0]  hue_c;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Max-colour select with r > g > b priority on ties, plus the hue operand pair.
  always_comb begin
    sel_c = SEL_R;
    mx_c  = r_q;
    in1_c = g_q;
    in2_c = b_q;
    if (r_q >= g_q && r_q >= b_q) begin
      sel_c = SEL_R; mx_c = r_q; in1_c = g_q; in2_c = b_q;
    end else if (g_q >= b_q) begin
      sel_c = SEL_G; mx_c = g_q; in1_c = b_q; in2_c = r_q;
    end else begin
      sel_c = SEL_B; mx_c = b_q; in1_c = r_q; in2_c = g_q;
    end
    mn_c   = (r_q < g_q) ? r_q : g_q;
    mn_c   = (mn_c < b_q) ? mn_c : b_q;
    diff_c = mx_c - mn_c;
    neg_c  = (in1_c < in2_c);
    num_c  = neg_c ? (in2_c - in1_c) : (in1_c - in2_c);
  end

  // One divider step; the denominator follows the active phase.
  always_comb begin
    den     = (state == DIV_SAT) ? mx : diff;
    ge      = (rem >= {1'b0, den});
    rem_sub = ge ? (rem - {1'b0, den}) : rem;
    rem_nxt = {rem_sub[7:0], 1'b0};
    q_nxt   = {quo[7:0], ge};
  end

  always_comb begin
    t_c   = 7'((15'(qh) * 15'd60) >> 8);
    sat_c = 7'((15'(qs) * 15'd127) >> 8);
    hue_c = '0;
    case (sel)
      SEL_R:   hue_c = neg ? ((t_c == 7'd0) ? 9'd0 : (9'd360 - 9'(t_c))) : 9'(t_c);
      SEL_G:   hue_c = neg ? (9'd120 - 9'(t_c)) : (9'd120 + 9'(t_c));
      SEL_B:   hue_c = neg ? (9'd240 - 9'(t_c)) : (9'd240 + 9'(t_c));
      default: hue_c = '0;
    endcase
    if (diff == 8'd0) begin
      hue_c = '0;
      sat_c = '0;
    end
    if (mx == 8'd0) sat_c = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= SEL_R;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      mx        <= '0;
      diff      <= '0;
      neg       <= 1'b0;
      rem       <= '0;
      quo       <= '0;
      qh        <= '0;
      qs        <= '0;
      cnt       <= '0;
      hsv       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r_q   <= r;
            g_q   <= g;
            b_q   <= b;
            state <= PREP;
          end
        end
        PREP: begin
          sel   <= sel_c;
          mx    <= mx_c;
          diff  <= diff_c;
          neg   <= neg_c;
          rem   <= {1'b0, num_c};
          quo   <= '0;
          cnt   <= '0;
          state <= (SKIP_ZERO != 0 && diff_c == 8'd0) ? POST : DIV_HUE;
        end
        DIV_HUE: begin
          rem <= rem_nxt;
          quo <= q_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) begin
            // Hand the datapath over to the saturation division.
            qh    <= q_nxt;
            rem   <= {1'b0, diff};
            quo   <= '0;
            cnt   <= '0;
            state <= DIV_SAT;
          end
        end
        DIV_SAT: begin
          rem <= rem_nxt;
          quo <= q_nxt;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd8) begin
            qs    <= q_nxt;
            state <= POST;
          end
        end
        POST: begin
          hsv       <= {hue_c, sat_c, mx};
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
